// File: rtl/ext_irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ext_irq_ctrl_pkg
// Purpose  : Shared definitions for the external interrupt controller:
//            register offsets, controller state encodings, the id width and
//            a fixed-priority helper (lowest index wins).
// Revision : 1.0 - initial release
// ============================================================================
package ext_irq_ctrl_pkg;

    // Register byte offsets; bits [3:2] select the register.
    localparam logic [3:0] c_IRQ_PEND  = 4'h0;
    localparam logic [3:0] c_IRQ_EN    = 4'h4;
    localparam logic [3:0] c_IRQ_EDGE  = 4'h8;
    localparam logic [3:0] c_IRQ_CLAIM = 4'hC;

    // Controller state encodings.
    localparam logic [1:0] c_ST_IDLE    = 2'b00;
    localparam logic [1:0] c_ST_ASSERT  = 2'b01;
    localparam logic [1:0] c_ST_CLAIMED = 2'b10;

    // Width of an interrupt id (id = source index + 1, 0 = none).
    localparam int c_ID_W = 5;

    // Returns index+1 of the lowest set bit, or 0 when no bit is set.
    // Scanning downwards lets the lowest index overwrite higher ones.
    function automatic logic [c_ID_W-1:0] f_prio_id(input logic [30:0] vec);
        logic [c_ID_W-1:0] id;
        id = '0;
        for (int i = 30; i >= 0; i--) begin
            if (vec[i]) begin
                id = c_ID_W'(i + 1);
            end
        end
        return id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ext_irq_ctrl_irq_gateway.sv
`default_nettype none
// ============================================================================
// Module   : irq_gateway
// Purpose  : One interrupt source: SYNC_STAGES-deep synchroniser, rising
//            edge detect and the pending flop.
//            Level mode : pending follows the synchronised level.
//            Edge mode  : pending sets on a synchronised 0->1 and clears on
//                         clr; a set in the same cycle as clr wins.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            irq_in          - asynchronous request line
//            edge_mode       - 1 = rising-edge mode, 0 = level mode
//            clr             - clear request (claim or W1C), edge mode only
//            pending         - registered pending state
// Revision : 1.0 - initial release
// ============================================================================
module irq_gateway #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    input  logic edge_mode,
    input  logic clr,
    output logic pending
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic                   r_pending;

    logic w_sync;
    logic w_rise;
    logic w_pending_nxt;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sync & ~r_sync_prev;

    always_comb begin
        w_pending_nxt = w_sync;
        if (edge_mode) begin
            w_pending_nxt = w_rise | (r_pending & ~clr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], irq_in};
            r_sync_prev <= w_sync;
            r_pending   <= w_pending_nxt;
        end
    end

    assign pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/ext_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ext_irq_ctrl
// Purpose  : External interrupt aggregator in front of the core. Gateways
//            each source, masks with ENABLE, picks the lowest eligible index
//            and runs a claim/complete handshake over a small register port.
//            Also raises a wake request while the core sits in WFI.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            irq_src         - NUM_SRC asynchronous request lines
//            core_wfi        - core is waiting for interrupt
//            ext_irq         - request to the core (high only in ASSERT)
//            irq_wake        - registered core_wfi & |(pending & ENABLE)
//            reg_wr/reg_rd   - single-cycle write/read strobes
//            reg_addr        - byte address, [3:2] selects the register
//            reg_wdata       - write data
//            reg_rdata       - registered read data
//            reg_rvld        - read data valid, one cycle after reg_rd
//            cpl_err         - sticky: complete written with a wrong id
// Registers: 0x0 PENDING (edge bits W1C), 0x4 ENABLE, 0x8 EDGE_SEL,
//            0xC CLAIM (read claims, write completes)
// Revision : 1.0 - initial release
// ============================================================================
module ext_irq_ctrl
    import ext_irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               core_wfi,
    output logic               ext_irq,
    output logic               irq_wake,
    input  logic               reg_wr,
    input  logic               reg_rd,
    input  logic [3:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               reg_rvld,
    output logic               cpl_err
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [c_ID_W-1:0]  r_in_service_id;
    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] r_edge_sel;
    logic [31:0]        r_reg_rdata;
    logic               r_reg_rvld;
    logic               r_cpl_err;
    logic               r_irq_wake;

    // ------------------------------------------------------------------
    // Register decode; a write that collides with a read is dropped.
    // ------------------------------------------------------------------
    logic [1:0] w_sel;
    logic       w_wr;
    logic       w_claim_rd;
    logic       w_cpl_wr;
    logic       w_w1c_wr;

    assign w_sel      = reg_addr[3:2];
    assign w_wr       = reg_wr & ~reg_rd;
    assign w_claim_rd = reg_rd & (w_sel == c_IRQ_CLAIM[3:2]);
    assign w_cpl_wr   = w_wr & (w_sel == c_IRQ_CLAIM[3:2]);
    assign w_w1c_wr   = w_wr & (w_sel == c_IRQ_PEND[3:2]);

    // ------------------------------------------------------------------
    // Gateways and per-source masks
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] w_pending;
    logic [NUM_SRC-1:0] w_in_service;
    logic [NUM_SRC-1:0] w_claim_clr;
    logic [NUM_SRC-1:0] w_gw_clr;
    logic [NUM_SRC-1:0] w_eligible;
    logic [c_ID_W-1:0]  w_win_id;
    logic               w_do_claim;

    assign w_eligible = w_pending & r_enable & ~w_in_service;
    assign w_win_id   = f_prio_id(31'(w_eligible));
    assign w_do_claim = w_claim_rd & (r_state == c_ST_ASSERT) & (|w_eligible);

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        // The in-service mask only exists while a claim is outstanding.
        assign w_in_service[i] = (r_state == c_ST_CLAIMED) &&
                                 (r_in_service_id == c_ID_W'(i + 1));
        assign w_claim_clr[i]  = w_do_claim && (w_win_id == c_ID_W'(i + 1));
        assign w_gw_clr[i]     = w_claim_clr[i] | (w_w1c_wr & reg_wdata[i]);

        irq_gateway #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_gateway (
            .clk       (clk),
            .rst       (rst),
            .irq_in    (irq_src[i]),
            .edge_mode (r_edge_sel[i]),
            .clr       (w_gw_clr[i]),
            .pending   (w_pending[i])
        );
    end

    // ------------------------------------------------------------------
    // Claim/complete FSM
    // ------------------------------------------------------------------
    logic [1:0]        w_state_nxt;
    logic [c_ID_W-1:0] w_in_service_nxt;
    logic              w_cpl_err_nxt;
    logic [c_ID_W-1:0] w_claim_rdata;

    always_comb begin
        w_state_nxt      = r_state;
        w_in_service_nxt = r_in_service_id;
        w_cpl_err_nxt    = r_cpl_err;
        w_claim_rdata    = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (|w_eligible) begin
                    w_state_nxt = c_ST_ASSERT;
                end
            end
            c_ST_ASSERT: begin
                if (w_do_claim) begin
                    w_state_nxt      = c_ST_CLAIMED;
                    w_in_service_nxt = w_win_id;
                    w_claim_rdata    = w_win_id;
                end else if (!(|w_eligible)) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_CLAIMED: begin
                if (w_cpl_wr) begin
                    if (reg_wdata[c_ID_W-1:0] == r_in_service_id) begin
                        w_state_nxt      = c_ST_IDLE;
                        w_in_service_nxt = '0;
                    end else begin
                        w_cpl_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt      = c_ST_IDLE;
                w_in_service_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] w_rdata;

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            c_IRQ_PEND[3:2]:  w_rdata = 32'(w_pending);
            c_IRQ_EN[3:2]:    w_rdata = 32'(r_enable);
            c_IRQ_EDGE[3:2]:  w_rdata = 32'(r_edge_sel);
            default:          w_rdata = 32'(w_claim_rdata);
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_ST_IDLE;
            r_in_service_id <= '0;
            r_enable        <= '0;
            r_edge_sel      <= '0;
            r_reg_rdata     <= '0;
            r_reg_rvld      <= 1'b0;
            r_cpl_err       <= 1'b0;
            r_irq_wake      <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_in_service_id <= w_in_service_nxt;
            r_cpl_err       <= w_cpl_err_nxt;
            r_reg_rvld      <= reg_rd;
            r_irq_wake      <= core_wfi & (|(w_pending & r_enable));
            if (reg_rd) begin
                r_reg_rdata <= w_rdata;
            end
            if (w_wr && (w_sel == c_IRQ_EN[3:2])) begin
                r_enable <= reg_wdata[NUM_SRC-1:0];
            end
            if (w_wr && (w_sel == c_IRQ_EDGE[3:2])) begin
                r_edge_sel <= reg_wdata[NUM_SRC-1:0];
            end
        end
    end

    assign ext_irq   = (r_state == c_ST_ASSERT);
    assign irq_wake  = r_irq_wake;
    assign reg_rdata = r_reg_rdata;
    assign reg_rvld  = r_reg_rvld;
    assign cpl_err   = r_cpl_err;

    // Byte-lane bits and write data above the implemented fields are don't-care.
    logic w_unused;
    assign w_unused = ^{reg_addr[1:0], reg_wdata};

endmodule
`default_nettype wire

// File: tb/tb_ext_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_irq_ctrl
// Purpose  : Directed self-checking bench for ext_irq_ctrl (NUM_SRC=8,
//            SYNC_STAGES=2). Expected values are hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ext_irq_ctrl;
    import ext_irq_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  irq_src;
    logic        core_wfi;
    logic        ext_irq;
    logic        irq_wake;
    logic        reg_wr;
    logic        reg_rd;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_rvld;
    logic        cpl_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    ext_irq_ctrl #(
        .NUM_SRC     (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src   (irq_src),
        .core_wfi  (core_wfi),
        .ext_irq   (ext_irq),
        .irq_wake  (irq_wake),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_rvld  (reg_rvld),
        .cpl_err   (cpl_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [3:0] a, output logic [31:0] d);
        reg_rd   = 1'b1;
        reg_addr = a;
        tick(1);
        reg_rd = 1'b0;
        d = reg_rdata;
        check("rvld", 32'(reg_rvld), 32'd1);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        reg_wr    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        tick(1);
        reg_wr = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        rst       = 1'b1;
        irq_src   = 8'hFF;
        core_wfi  = 1'b0;
        reg_wr    = 1'b0;
        reg_rd    = 1'b0;
        reg_addr  = 4'h0;
        reg_wdata = 32'h0;

        // ---------------- reset ----------------
        tick(3);
        check("rst_ext_irq",  32'(ext_irq),  32'd0);
        check("rst_irq_wake", 32'(irq_wake), 32'd0);
        check("rst_rvld",     32'(reg_rvld), 32'd0);
        check("rst_cpl_err",  32'(cpl_err),  32'd0);
        rst = 1'b0;
        // Reads at E0..E2 see 0; pending lands at E2 so the E3 read sees it.
        do_read(c_IRQ_PEND, rd); check("pend_e0", rd, 32'h00);
        do_read(c_IRQ_PEND, rd); check("pend_e1", rd, 32'h00);
        do_read(c_IRQ_PEND, rd); check("pend_e2", rd, 32'h00);
        do_read(c_IRQ_PEND, rd); check("pend_e3", rd, 32'hFF);
        tick(1);
        check("rvld_drop", 32'(reg_rvld), 32'd0);
        irq_src = 8'h00;
        tick(4);

        // ---------------- level mode ----------------
        do_write(c_IRQ_EN, 32'h04);
        irq_src = 8'h04;
        tick(3);
        check("lvl_e2_low", 32'(ext_irq), 32'd0);
        tick(1);
        check("lvl_e3_high", 32'(ext_irq), 32'd1);
        do_read(c_IRQ_CLAIM, rd);
        check("lvl_claim", rd, 32'd3);
        check("lvl_claimed_low", 32'(ext_irq), 32'd0);
        do_write(c_IRQ_CLAIM, 32'd3);
        check("lvl_cpl_idle", 32'(ext_irq), 32'd0);
        tick(1);
        check("lvl_reassert", 32'(ext_irq), 32'd1);
        irq_src = 8'h00;
        tick(4);
        check("lvl_drop_idle", 32'(ext_irq), 32'd0);
        do_write(c_IRQ_EN, 32'h00);

        // ---------------- edge mode ----------------
        do_write(c_IRQ_EDGE, 32'h01);
        do_write(c_IRQ_EN,   32'h01);
        irq_src = 8'h01; tick(1); irq_src = 8'h00;
        tick(3);
        check("edg_assert", 32'(ext_irq), 32'd1);
        do_read(c_IRQ_PEND, rd);
        check("edg_pend_set", rd, 32'h01);
        do_read(c_IRQ_CLAIM, rd);
        check("edg_claim", rd, 32'd1);
        do_read(c_IRQ_PEND, rd);
        check("edg_pend_clr", rd, 32'h00);
        irq_src = 8'h01; tick(1); irq_src = 8'h00;
        tick(3);
        do_read(c_IRQ_PEND, rd);
        check("edg_pend_again", rd, 32'h01);
        check("edg_insvc_low", 32'(ext_irq), 32'd0);
        do_write(c_IRQ_CLAIM, 32'd1);
        tick(1);
        check("edg_reassert", 32'(ext_irq), 32'd1);
        do_read(c_IRQ_CLAIM, rd);
        check("edg_claim2", rd, 32'd1);
        do_write(c_IRQ_CLAIM, 32'd1);
        // W1C on an edge-mode pending bit.
        irq_src = 8'h01; tick(1); irq_src = 8'h00;
        tick(3);
        check("w1c_assert", 32'(ext_irq), 32'd1);
        do_write(c_IRQ_PEND, 32'h01);
        do_read(c_IRQ_PEND, rd);
        check("w1c_pend", rd, 32'h00);
        check("w1c_idle", 32'(ext_irq), 32'd0);
        do_write(c_IRQ_EDGE, 32'h00);

        // ---------------- priority and wrong complete ----------------
        do_write(c_IRQ_EN, 32'h22);
        irq_src = 8'h22;
        tick(4);
        check("pri_assert", 32'(ext_irq), 32'd1);
        do_read(c_IRQ_CLAIM, rd);
        check("pri_claim_hi", rd, 32'd2);
        do_write(c_IRQ_CLAIM, 32'd4);
        check("bad_cpl_err", 32'(cpl_err), 32'd1);
        check("bad_cpl_stay", 32'(ext_irq), 32'd0);
        do_read(c_IRQ_CLAIM, rd);
        check("claim_in_claimed", rd, 32'd0);
        irq_src = 8'h20;
        tick(3);
        do_write(c_IRQ_CLAIM, 32'd2);
        tick(1);
        check("pri_reassert", 32'(ext_irq), 32'd1);
        do_read(c_IRQ_CLAIM, rd);
        check("pri_claim_lo", rd, 32'd6);
        do_write(c_IRQ_CLAIM, 32'd6);
        check("cpl_err_sticky", 32'(cpl_err), 32'd1);
        irq_src = 8'h00;
        do_write(c_IRQ_EN, 32'h00);
        tick(4);

        // ---------------- WFI wake ----------------
        core_wfi = 1'b1;
        do_write(c_IRQ_EN, 32'h80);
        irq_src = 8'h80;
        tick(3);
        check("wake_e2_low", 32'(irq_wake), 32'd0);
        tick(1);
        check("wake_e3_high", 32'(irq_wake), 32'd1);
        do_write(c_IRQ_EN, 32'h00);
        check("wake_hold", 32'(irq_wake), 32'd1);
        tick(1);
        check("wake_drop", 32'(irq_wake), 32'd0);
        do_read(c_IRQ_CLAIM, rd);
        check("claim_idle", rd, 32'd0);
        check("idle_low", 32'(ext_irq), 32'd0);

        // ---------------- read and write together ----------------
        reg_rd    = 1'b1;
        reg_wr    = 1'b1;
        reg_addr  = c_IRQ_EN;
        reg_wdata = 32'hFF;
        tick(1);
        reg_rd = 1'b0;
        reg_wr = 1'b0;
        check("rdwr_rdata", reg_rdata, 32'h00);
        do_read(c_IRQ_EN, rd);
        check("rdwr_no_write", rd, 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ext_irq_ctrl.md
Name: ext_irq_ctrl

Overview:
- Interrupt aggregator directly upstream of the core top; drives its external-interrupt input.
- Synchronises NUM_SRC asynchronous sources and latches each in a per-source gateway (level or rising-edge).
- Masks the sources and picks the winner by fixed priority; lowest index is highest priority.
- Runs a claim/complete handshake over a small register port. Also raises a wake request while the core reports WFI.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..31).
- SYNC_STAGES, 2, synchroniser depth on each irq_src bit (>=2).

Ports:
- clk  in  1  core clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- irq_src  in  NUM_SRC  asynchronous interrupt request lines.
- core_wfi  in  1  core is in wait-for-interrupt.
- ext_irq  out  1  interrupt request to the core's external-interrupt input.
- irq_wake  out  1  wake request (pending, enabled and core_wfi).
- reg_wr  in  1  register write strobe, single cycle.
- reg_rd  in  1  register read strobe, single cycle.
- reg_addr  in  4  byte address; bits [3:2] select the register.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data, registered.
- reg_rvld  out  1  read data valid, one cycle after reg_rd.
- cpl_err  out  1  sticky flag: complete written with a wrong id.

Behaviour:
- Reset: all outputs 0; PENDING, ENABLE, EDGE_SEL and all synchronisers cleared; FSM in IDLE.
- Registers:
  - 0x0 PENDING: read returns pending. W1C applies to edge-mode bits only.
  - 0x4 ENABLE: R/W mask.
  - 0x8 EDGE_SEL: R/W; 1 = rising-edge mode, 0 = level mode.
  - 0xC CLAIM: read claims; write completes.
  - Bits above NUM_SRC read 0 and ignore writes.
- Gateway (per source):
  - Input passes SYNC_STAGES flops.
  - Level mode: pending = synchronised level.
  - Edge mode: pending sets on a 0->1 of the synchronised signal. It clears on claim of that id or on W1C.
  - If set and clear happen in the same cycle, set wins.
  - An in-service source cannot be re-claimed before complete. Edge events arriving meanwhile stay latched.
- Eligible = pending & ENABLE & ~in_service. Winner = lowest eligible index; id = index+1; 0 means none.
- FSM:
  - IDLE -> ASSERT when any source is eligible.
  - ASSERT -> CLAIMED on a CLAIM read: return the winner id, record it as in-service, clear its edge pending.
  - ASSERT -> IDLE if eligible becomes empty (level drop or disable) before a claim; ext_irq drops.
  - CLAIMED -> IDLE on a CLAIM write with wdata[4:0] equal to the in-service id.
  - A mismatched complete is ignored and sets cpl_err.
- ext_irq = 1 exactly in ASSERT (registered state decode).
- Latency with SYNC_STAGES=2: irq_src first sampled high at edge E0 -> pending after E2 -> ext_irq high after E3.
- Reads:
  - reg_rdata is captured at the reg_rd edge; reg_rvld pulses the next cycle.
  - A CLAIM read in IDLE or CLAIMED returns 0 with no side effect.
  - If reg_rd and reg_wr are asserted together, the write is ignored.
- irq_wake is registered: core_wfi & |(pending & ENABLE). Independent of FSM state.
- Mid-operation reset: returns to IDLE at the next edge; in-service and pending are lost.
- ENABLE cleared while CLAIMED: no effect until complete.
- Priority ties cannot occur (indices are unique).

Decomposition:
- Shared defines file (alongside the existing mcu defines):
  - register offsets: IRQ_PEND 0x0, IRQ_EN 0x4, IRQ_EDGE 0x8, IRQ_CLAIM 0xC;
  - FSM encodings: IDLE 2'b00, ASSERT 2'b01, CLAIMED 2'b10;
  - ID_W = 5.
- Sub-module irq_gateway: synchroniser, edge detect and pending flop for one source; instantiated NUM_SRC times.
- Priority encoder, FSM and register file stay in ext_irq_ctrl.

Test Plan:
- Reset with irq_src=8'hFF -> ext_irq, irq_wake, reg_rvld, cpl_err all 0; PENDING reads 0 until 3 cycles after rst deassert.
- Level mode: ENABLE=0x04, irq_src[2]=1 -> ext_irq high 3 edges later. Read CLAIM -> 3; ext_irq low next cycle. Write CLAIM=3 -> IDLE; source still high so ext_irq re-asserts.
- Edge mode: EDGE_SEL=0x01, ENABLE=0x01, one-cycle pulse on irq_src[0] -> PENDING bit0 latched. Claim returns 1 and bit0 clears. A second pulse before complete stays pending and re-asserts after complete.
- Priority: sources 5 and 1 both pending and enabled -> claim returns 2. After complete=2 -> claim returns 6.
- Wrong complete: in service id 2, write CLAIM=4 -> cpl_err=1, state stays CLAIMED. Write 2 -> IDLE.
- WFI wake: core_wfi=1, ENABLE=0x80, irq_src[7] rises -> irq_wake high after E3. ENABLE=0 -> irq_wake low next cycle. CLAIM read while IDLE -> 0.
